mic_mem_dp: RTL and testbench

- Parametrised successor to the single-port MIC main store: one word port (MAR/MDR) for data access and one byte fetch port (PC/MBR) for instruction stream, sharing one storage array.
- Configurable width, depth and access latency; each port runs its own busy/valid handshake and flags out-of-range addresses.
- Sits between the datapath registers (MAR, MDR, PC, MBR) and the microsequencer, which polls busy/valid instead of assuming fixed timing.

---
 rtl/mic_mem_dp_if.sv | 29 ++
 rtl/mic_mem_dp.sv | 95 +++++++++
 tb/tb_mic_mem_dp.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mic_mem_dp_if.sv
// mic_mem_dp_if: word (MAR/MDR) and byte fetch (PC/MBR) request/response bundle for mic_mem_dp
interface mic_mem_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr_in;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] mdr_out;
    logic              word_busy;
    logic              word_valid;
    logic              word_err;
    logic [ADDR_W-1:0] pc;
    logic              fetch;
    logic [7:0]        mbr_out;
    logic              fetch_busy;
    logic              fetch_valid;
    logic              fetch_err;

    modport master (
        output mar, mdr_in, rd, wr, pc, fetch,
        input  mdr_out, word_busy, word_valid, word_err, mbr_out, fetch_busy, fetch_valid, fetch_err
    );
    modport slave (
        input  mar, mdr_in, rd, wr, pc, fetch,
        output mdr_out, word_busy, word_valid, word_err, mbr_out, fetch_busy, fetch_valid, fetch_err
    );
endinterface

// File: rtl/mic_mem_dp.sv
// mic_mem_dp: MIC main store with a word MAR/MDR port and a byte PC/MBR fetch port over one array,
// each port running its own busy/valid handshake with configurable latency.
module mic_mem_dp #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    mic_mem_dp_if.slave  io_mem
);
    localparam int BSEL_W = $clog2(DATA_W / 8);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] w_fidx;
    logic              w_wacc, w_facc, w_woor, w_foor, w_wr_en;
    logic [DATA_W-1:0] w_wdata, w_fword;
    logic [7:0]        w_fbyte;
    logic [CNT_W-1:0]  r_wcnt, r_fcnt;
    logic              r_wrd, r_werr, r_ferr;
    logic [DATA_W-1:0] r_wdata, r_mdr;
    logic [7:0]        r_fbyte, r_mbr;

    // counter holds cycles left: >1 busy, ==1 valid, 0 idle; accept whenever not busy
    always_comb begin
        w_fidx  = io_mem.pc >> BSEL_W;
        w_woor  = io_mem.mar >= ADDR_W'(DEPTH);
        w_foor  = w_fidx >= ADDR_W'(DEPTH);
        w_wacc  = reset && (io_mem.rd || io_mem.wr) && r_wcnt <= ONE;
        w_facc  = reset && io_mem.fetch && r_fcnt <= ONE;
        w_wr_en = w_wacc && !io_mem.rd && !w_woor;
        w_wdata = w_woor ? '0 : r_mem[io_mem.mar[IDX_W-1:0]];
        w_fword = w_foor ? '0 : r_mem[w_fidx[IDX_W-1:0]];
        w_fbyte = w_fword[{io_mem.pc[BSEL_W-1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[io_mem.mar[IDX_W-1:0]] <= io_mem.mdr_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wcnt  <= '0;
            r_wrd   <= 1'b0;
            r_werr  <= 1'b0;
            r_wdata <= '0;
            r_mdr   <= '0;
        end else begin
            if (w_wacc) begin
                r_wcnt  <= LAT;
                r_wrd   <= io_mem.rd;
                r_werr  <= w_woor;
                r_wdata <= w_wdata;
            end else if (r_wcnt != '0) begin
                r_wcnt <= r_wcnt - ONE;
            end
            if (LATENCY == 1 ? (w_wacc && io_mem.rd) : (r_wcnt == TWO && r_wrd))
                r_mdr <= LATENCY == 1 ? w_wdata : r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fcnt  <= '0;
            r_ferr  <= 1'b0;
            r_fbyte <= '0;
            r_mbr   <= '0;
        end else begin
            if (w_facc) begin
                r_fcnt  <= LAT;
                r_ferr  <= w_foor;
                r_fbyte <= w_fbyte;
            end else if (r_fcnt != '0) begin
                r_fcnt <= r_fcnt - ONE;
            end
            if (LATENCY == 1 ? w_facc : r_fcnt == TWO)
                r_mbr <= LATENCY == 1 ? w_fbyte : r_fbyte;
        end
    end

    assign io_mem.mdr_out     = r_mdr;
    assign io_mem.word_busy   = r_wcnt > ONE;
    assign io_mem.word_valid  = r_wcnt == ONE;
    assign io_mem.word_err    = r_wcnt == ONE && r_werr;
    assign io_mem.mbr_out     = r_mbr;
    assign io_mem.fetch_busy  = r_fcnt > ONE;
    assign io_mem.fetch_valid = r_fcnt == ONE;
    assign io_mem.fetch_err   = r_fcnt == ONE && r_ferr;
endmodule

// File: tb/tb_mic_mem_dp.sv
// tb_mic_mem_dp: scoreboard bench over three mic_mem_dp configurations
// (32b/LAT1, 32b/LAT3, 16b x16/LAT4).
module tb_mic_mem_dp;
    localparam int LATS [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic [2:0]  rstn, rd, wr, fetch;
    logic [31:0] mar [3], mdr_in [3], pc [3], mdr_o [3];
    logic [7:0]  mbr_o [3];
    logic [2:0]  wbusy, wvalid, werr, fbusy, fvalid, ferr;
    logic [32:0] wq [3][$];
    logic [8:0]  fq [3][$];
    int          n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DW  = g == 2 ? 16 : 32;
        localparam int DEP = g == 2 ? 16 : 256;
        mic_mem_dp_if #(.DATA_W(DW), .ADDR_W(32)) bus ();
        assign bus.mar    = mar[g];
        assign bus.mdr_in = mdr_in[g][DW-1:0];
        assign bus.rd     = rd[g];
        assign bus.wr     = wr[g];
        assign bus.pc     = pc[g];
        assign bus.fetch  = fetch[g];
        assign mdr_o[g]   = 32'(bus.mdr_out);
        assign mbr_o[g]   = bus.mbr_out;
        assign wbusy[g]   = bus.word_busy;
        assign wvalid[g]  = bus.word_valid;
        assign werr[g]    = bus.word_err;
        assign fbusy[g]   = bus.fetch_busy;
        assign fvalid[g]  = bus.fetch_valid;
        assign ferr[g]    = bus.fetch_err;
        mic_mem_dp #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(32), .LATENCY(LATS[g])) u_dut (
            .clk    (clk),
            .reset  (rstn[g]),
            .io_mem (bus)
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every completion pulse pops and checks one expected {err, data}
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wvalid[k]) begin
                if (wq[k].size() == 0) chk("word_unexpected_valid", 64'(k + 1), 64'(0));
                else chk("word_result", {31'b0, werr[k], mdr_o[k]}, 64'(wq[k].pop_front()));
            end
            if (fvalid[k]) begin
                if (fq[k].size() == 0) chk("fetch_unexpected_valid", 64'(k + 1), 64'(0));
                else chk("fetch_result", {55'b0, ferr[k], mbr_o[k]}, 64'(fq[k].pop_front()));
            end
        end
    end

    task automatic word_op(input int k, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [32:0] e);
        int nb = 0;
        logic done = 1'b0;
        rd[k] = r; wr[k] = w; mar[k] = a; mdr_in[k] = d;
        wq[k].push_back(e);
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (wvalid[k]) done = 1'b1;
            else if (wbusy[k]) nb++;
        end
        chk("word_done", 64'(done), 64'(1));
        chk("word_busy_cycles", 64'(nb), 64'(LATS[k] - 1));
    endtask

    task automatic fetch_op(input int k, input logic [31:0] a, input logic hold, input logic [8:0] e);
        int nb = 0;
        logic done = 1'b0;
        fetch[k] = 1'b1; pc[k] = a;
        fq[k].push_back(e);
        @(posedge clk); #1;
        if (hold) pc[k] = a + 1;
        else fetch[k] = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (fvalid[k]) done = 1'b1;
            else if (fbusy[k]) nb++;
        end
        fetch[k] = 1'b0;
        chk("fetch_done", 64'(done), 64'(1));
        chk("fetch_busy_cycles", 64'(nb), 64'(LATS[k] - 1));
    endtask

    task automatic abort_op(input int k, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int n);
        int nv = 0;
        rd[k] = r; wr[k] = w; mar[k] = a; mdr_in[k] = d;
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
        repeat (n) @(negedge clk);
        rstn[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_state", 64'({mdr_o[k], mbr_o[k], wbusy[k], wvalid[k], werr[k], fbusy[k], fvalid[k], ferr[k]}), 64'(0));
        rstn[k] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            nv += int'(wvalid[k]);
        end
        chk("abort_no_valid", 64'(nv), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rstn = '0; rd = '0; wr = '0; fetch = '0;
        for (int k = 0; k < 3; k++) begin
            mar[k] = '0; mdr_in[k] = '0; pc[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk("reset_state", 64'({mdr_o[k], mbr_o[k], wbusy[k], wvalid[k], werr[k], fbusy[k], fvalid[k], ferr[k]}), 64'(0));
        rstn = '1;
        // LATENCY=1, 32-bit x256
        word_op(0, 0, 1, 21, 32'h64, {1'b0, 32'h0});
        word_op(0, 1, 0, 21, 0, {1'b0, 32'h64});
        word_op(0, 0, 1, 3, 0, {1'b0, 32'h64});
        word_op(0, 1, 1, 3, 32'hFF, {1'b0, 32'h0});
        word_op(0, 1, 0, 3, 0, {1'b0, 32'h0});
        word_op(0, 0, 1, 0, 32'h1234, {1'b0, 32'h0});
        word_op(0, 1, 0, 21, 0, {1'b0, 32'h64});
        word_op(0, 1, 0, 256, 0, {1'b1, 32'h0});
        word_op(0, 0, 1, 256, 32'h99, {1'b1, 32'h0});
        word_op(0, 1, 0, 0, 0, {1'b0, 32'h1234});
        fetch_op(0, 0, 0, {1'b0, 8'h34});
        fetch_op(0, 1024, 0, {1'b1, 8'h00});
        fetch_op(0, 1, 0, {1'b0, 8'h12});
        fork
            word_op(0, 1, 0, 21, 0, {1'b0, 32'h64});
            fetch_op(0, 84, 0, {1'b0, 8'h64});
        join
        // LATENCY=3, 32-bit x256
        word_op(1, 0, 1, 5, 32'hA1B2C3D4, {1'b0, 32'h0});
        word_op(1, 0, 1, 7, 32'h11, {1'b0, 32'h0});
        fetch_op(1, 20, 1, {1'b0, 8'hD4});
        fetch_op(1, 21, 0, {1'b0, 8'hC3});
        fetch_op(1, 22, 0, {1'b0, 8'hB2});
        fetch_op(1, 23, 0, {1'b0, 8'hA1});
        fork
            word_op(1, 0, 1, 7, 32'h22, {1'b0, 32'h0});
            fetch_op(1, 28, 0, {1'b0, 8'h11});
        join
        word_op(1, 1, 0, 7, 0, {1'b0, 32'h22});
        // LATENCY=4, 16-bit x16
        word_op(2, 0, 1, 15, 32'hBEEF, {1'b0, 32'h0});
        fetch_op(2, 32, 0, {1'b1, 8'h00});
        fetch_op(2, 30, 0, {1'b0, 8'hEF});
        fetch_op(2, 31, 0, {1'b0, 8'hBE});
        word_op(2, 1, 0, 16, 0, {1'b1, 32'h0});
        word_op(2, 1, 0, 15, 0, {1'b0, 32'hBEEF});
        abort_op(2, 0, 1, 4, 32'h7777, 1);
        word_op(2, 1, 0, 15, 0, {1'b0, 32'hBEEF});
        fetch_op(2, 31, 0, {1'b0, 8'hBE});
        abort_op(2, 1, 0, 15, 0, 2);
        word_op(2, 1, 0, 4, 0, {1'b0, 32'h7777});
        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(wq[0].size() + wq[1].size() + wq[2].size() + fq[0].size() + fq[1].size() + fq[2].size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
